// File: rtl/pvr_vert_pkg.sv
// Shared constants and types for the PVR strip vertex feeder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pvr_vert_pkg;

    // Field slots within one stored vertex
    localparam int F_X = 0;
    localparam int F_Y = 1;
    localparam int F_Z = 2;
    localparam int F_U = 3;
    localparam int F_V = 4;

    localparam int NUM_FIELDS = 5;
    localparam int RING_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Modulo-3 increment for ring slot pointers
    function automatic logic [1:0] ring_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/pvr_vert_ring.sv
// Three-slot vertex register file, five float fields per slot, written per field.
// Latency: writes land on the next edge; reads are combinational from wp.
// Backpressure: none; the owner simply stops strobing writes while emitting.
// Ports: wp = slot being filled (also the oldest slot once the ring is full),
//        wr_stb/wr_dat = per-field write strobes and data,
//        rd_old/rd_mid/rd_new = slots wp, wp+1, wp+2 (mod 3).
module pvr_vert_ring
    import pvr_vert_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [1:0]                            wp,
    input  logic [NUM_FIELDS-1:0]                 wr_stb,
    input  logic [NUM_FIELDS-1:0][DATA_W-1:0]     wr_dat,
    output logic [NUM_FIELDS-1:0][DATA_W-1:0]     rd_old,
    output logic [NUM_FIELDS-1:0][DATA_W-1:0]     rd_mid,
    output logic [NUM_FIELDS-1:0][DATA_W-1:0]     rd_new
);

    logic [NUM_FIELDS-1:0][DATA_W-1:0] mem [RING_DEPTH];
    logic [1:0] p_mid;
    logic [1:0] p_new;

    // wp has already advanced past the newest vertex, so it names the oldest
    assign p_mid = ring_inc(wp);
    assign p_new = ring_inc(p_mid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < RING_DEPTH; s++) begin
                mem[s] <= '0;
            end
        end else begin
            for (int f = 0; f < NUM_FIELDS; f++) begin
                if (wr_stb[f]) begin
                    mem[wp][f] <= wr_dat[f];
                end
            end
        end
    end

    assign rd_old = mem[wp];
    assign rd_mid = mem[p_mid];
    assign rd_new = mem[p_new];

endmodule

// File: rtl/pvr_strip_vert_feed.sv
// Unpacks an ISP triangle-strip word stream into XYZUV vertices and emits each triangle as 3 beats.
// Latency: final vertex word accepted in cycle N -> first beat valid in cycle N+1; beats back-to-back.
// Backpressure: out_ready low stalls EMIT indefinitely; input is refused (in_ready=0) while emitting.
// Ports: strip_start/tex_en/skip_words configure a strip from IDLE; in_* is the word stream
//        (valid/ready, in_eos on a vertex's last word); out_* carries one vertex per beat with
//        out_vert = position in triangle; err_short flags strips under 3 vertices; busy = not IDLE.
module pvr_strip_vert_feed
    import pvr_vert_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKIP_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              strip_start,
    input  logic              tex_en,
    input  logic [SKIP_W-1:0] skip_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_eos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_float_1,
    output logic [DATA_W-1:0] out_float_2,
    output logic [DATA_W-1:0] out_float_3,
    output logic [DATA_W-1:0] out_float_4,
    output logic [DATA_W-1:0] out_float_5,
    output logic [1:0]        out_vert,
    output logic              out_tri_last,
    output logic              err_short,
    output logic              busy
);

    // Word counter must reach 2 + 2 + (2^SKIP_W - 1)
    localparam int CW = SKIP_W + 2;

    state_t            state;
    logic              tex_q;
    logic [SKIP_W-1:0] skip_q;
    logic [CW-1:0]     wcnt;
    logic [1:0]        vcnt;
    logic [1:0]        wp;
    logic [1:0]        beat;
    logic              tri_idx;
    logic              eos_pend;

    logic [CW-1:0]     last_idx;
    logic              in_xfer;
    logic              out_xfer;
    logic              last_word;

    logic [NUM_FIELDS-1:0]             wr_stb;
    logic [NUM_FIELDS-1:0][DATA_W-1:0] wr_dat;
    logic [NUM_FIELDS-1:0][DATA_W-1:0] rd_old;
    logic [NUM_FIELDS-1:0][DATA_W-1:0] rd_mid;
    logic [NUM_FIELDS-1:0][DATA_W-1:0] rd_new;
    logic [NUM_FIELDS-1:0][DATA_W-1:0] sel;

    assign in_ready  = (state == COLLECT);
    assign busy      = (state != IDLE);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_idx  = CW'(2) + (tex_q ? CW'(2) : CW'(0)) + CW'(skip_q);
    assign last_word = (wcnt == last_idx);

    // Route each accepted word to its field. Fields go straight into the slot at wp:
    // that slot holds the vertex which just dropped out of the window, so it is free.
    always_comb begin
        wr_stb = '0;
        wr_dat = '0;
        if (in_xfer) begin
            if (wcnt == CW'(0)) begin
                wr_stb[F_X] = 1'b1;
                wr_dat[F_X] = in_data;
                // Untextured strips: zero U/V alongside X (wr_dat defaults to 0)
                if (!tex_q) begin
                    wr_stb[F_U] = 1'b1;
                    wr_stb[F_V] = 1'b1;
                end
            end else if (wcnt == CW'(1)) begin
                wr_stb[F_Y] = 1'b1;
                wr_dat[F_Y] = in_data;
            end else if (wcnt == CW'(2)) begin
                wr_stb[F_Z] = 1'b1;
                wr_dat[F_Z] = in_data;
            end else if (wcnt == CW'(3) && tex_q) begin
                wr_stb[F_U] = 1'b1;
                wr_dat[F_U] = in_data;
            end else if (wcnt == CW'(4) && tex_q) begin
                wr_stb[F_V] = 1'b1;
                wr_dat[F_V] = in_data;
            end
        end
    end

    pvr_vert_ring #(
        .DATA_W (DATA_W)
    ) u_ring (
        .clock  (clock),
        .reset  (reset),
        .wp     (wp),
        .wr_stb (wr_stb),
        .wr_dat (wr_dat),
        .rd_old (rd_old),
        .rd_mid (rd_mid),
        .rd_new (rd_new)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tex_q     <= 1'b0;
            skip_q    <= '0;
            wcnt      <= '0;
            vcnt      <= 2'd0;
            wp        <= 2'd0;
            beat      <= 2'd0;
            tri_idx   <= 1'b0;
            eos_pend  <= 1'b0;
            out_valid <= 1'b0;
            err_short <= 1'b0;
        end else begin
            err_short <= 1'b0;
            case (state)
                IDLE: begin
                    if (strip_start) begin
                        state   <= COLLECT;
                        tex_q   <= tex_en;
                        skip_q  <= skip_words;
                        vcnt    <= 2'd0;
                        wcnt    <= '0;
                        tri_idx <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (in_xfer) begin
                        if (last_word) begin
                            wcnt <= '0;
                            wp   <= ring_inc(wp);
                            if (vcnt >= 2'd2) begin
                                vcnt      <= 2'd3;
                                state     <= EMIT;
                                eos_pend  <= in_eos;
                                out_valid <= 1'b1;
                                beat      <= 2'd0;
                            end else begin
                                vcnt <= vcnt + 2'd1;
                                if (in_eos) begin
                                    err_short <= 1'b1;
                                    state     <= IDLE;
                                end
                            end
                        end else begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_xfer) begin
                        if (beat == 2'd2) begin
                            out_valid <= 1'b0;
                            beat      <= 2'd0;
                            tri_idx   <= ~tri_idx;
                            state     <= eos_pend ? IDLE : COLLECT;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Odd triangles swap the first two vertices to keep strip winding consistent
    always_comb begin
        sel = '0;
        if (out_valid) begin
            case (beat)
                2'd0:    sel = tri_idx ? rd_mid : rd_old;
                2'd1:    sel = tri_idx ? rd_old : rd_mid;
                default: sel = rd_new;
            endcase
        end
    end

    assign out_float_1  = sel[F_X];
    assign out_float_2  = sel[F_Y];
    assign out_float_3  = sel[F_Z];
    assign out_float_4  = sel[F_U];
    assign out_float_5  = sel[F_V];
    assign out_vert     = beat;
    assign out_tri_last = out_valid && eos_pend && (beat == 2'd2);

endmodule
